// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_gen
// Description : Parametrised raster timing generator with programmable sync
//               polarity, enable/stall, line/frame strobes and frame counter.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
    parameter int H_VISIBLE  = 640,
    parameter int H_FRONT    = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BACK     = 48,
    parameter int V_VISIBLE  = 480,
    parameter int V_FRONT    = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BACK     = 33,
    parameter int H_SYNC_POL = 0,
    parameter int V_SYNC_POL = 0,
    parameter int PIPE_DELAY = 1,
    parameter int COORD_W    = 10,
    parameter int FCOUNT_W   = 8
) (
    input  logic                vga_clock,
    input  logic                vga_reset_n,
    input  logic                enable,
    output logic [COORD_W-1:0]  vga_col,
    output logic [COORD_W-1:0]  vga_row,
    output logic                vga_valid,
    output logic                h_sync,
    output logic                v_sync,
    output logic                line_start,
    output logic                frame_start,
    output logic [FCOUNT_W-1:0] frame_count
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    generate
        if (H_VISIBLE <= 0 || H_FRONT <= 0 || H_SYNC <= 0 || H_BACK <= 0 ||
            V_VISIBLE <= 0 || V_FRONT <= 0 || V_SYNC <= 0 || V_BACK <= 0) begin : g_bad_field
            $error("vga_timing_gen: every timing field must be non-zero");
        end
        if (PIPE_DELAY < 1 || PIPE_DELAY > 8) begin : g_bad_delay
            $error("vga_timing_gen: PIPE_DELAY must be in 1..8");
        end
        if (((H_TOTAL - 1) >> COORD_W) != 0 || ((V_TOTAL - 1) >> COORD_W) != 0) begin : g_bad_width
            $error("vga_timing_gen: COORD_W too narrow for H_TOTAL/V_TOTAL");
        end
    endgenerate

    localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_TOTAL - 1);
    localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_TOTAL - 1);
    localparam logic [COORD_W-1:0] H_VIS    = COORD_W'(H_VISIBLE);
    localparam logic [COORD_W-1:0] V_VIS    = COORD_W'(V_VISIBLE);
    localparam logic [COORD_W-1:0] HS_START = COORD_W'(H_VISIBLE + H_FRONT);
    localparam logic [COORD_W-1:0] HS_END   = COORD_W'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [COORD_W-1:0] VS_START = COORD_W'(V_VISIBLE + V_FRONT);
    localparam logic [COORD_W-1:0] VS_END   = COORD_W'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam logic               HS_ON    = (H_SYNC_POL != 0);
    localparam logic               VS_ON    = (V_SYNC_POL != 0);

    // Flag bundle order: {frame_start, line_start, v_sync, h_sync, valid}
    localparam logic [4:0]         FLAGS_IDLE = {1'b0, 1'b0, ~VS_ON, ~HS_ON, 1'b0};

    logic [COORD_W-1:0]  col;
    logic [COORD_W-1:0]  row;
    logic [FCOUNT_W-1:0] fcount;
    logic [4:0]          decode;
    logic                hs_act;
    logic                vs_act;
    logic [4:0]          pipe [PIPE_DELAY];

    always_ff @(posedge vga_clock or negedge vga_reset_n) begin
        if (!vga_reset_n) begin
            col    <= '0;
            row    <= '0;
            fcount <= '0;
        end else if (enable) begin
            if (col == H_LAST) begin
                col <= '0;
                if (row == V_LAST) begin
                    row    <= '0;
                    fcount <= fcount + FCOUNT_W'(1);
                end else begin
                    row <= row + COORD_W'(1);
                end
            end else begin
                col <= col + COORD_W'(1);
            end
        end
    end

    always_comb begin
        hs_act = (col >= HS_START) && (col < HS_END);
        vs_act = (row >= VS_START) && (row < VS_END);
        decode = {(col == '0) && (row == '0),
                  (col == '0),
                  vs_act ? VS_ON : ~VS_ON,
                  hs_act ? HS_ON : ~HS_ON,
                  (col < H_VIS) && (row < V_VIS)};
    end

    // Delay line aligns the flags with the renderer's pixel latency.
    always_ff @(posedge vga_clock or negedge vga_reset_n) begin
        if (!vga_reset_n) begin
            for (int i = 0; i < PIPE_DELAY; i++) begin
                pipe[i] <= FLAGS_IDLE;
            end
        end else if (enable) begin
            pipe[0] <= decode;
            for (int i = 1; i < PIPE_DELAY; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign vga_col     = col;
    assign vga_row     = row;
    assign frame_count = fcount;
    assign frame_start = pipe[PIPE_DELAY-1][4];
    assign line_start  = pipe[PIPE_DELAY-1][3];
    assign v_sync      = pipe[PIPE_DELAY-1][2];
    assign h_sync      = pipe[PIPE_DELAY-1][1];
    assign vga_valid   = pipe[PIPE_DELAY-1][0];

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_timing_gen
// Description : Directed self-checking bench: default 640x480 timing with a
//               3-stage delay, and a tiny raster with positive syncs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

    logic       clk = 1'b0;
    logic       a_rst_n, a_en, b_rst_n, b_en;
    logic [9:0] a_col, a_row;
    logic       a_valid, a_hs, a_vs, a_ls, a_fs;
    logic [7:0] a_fc;
    logic [3:0] b_col, b_row;
    logic       b_valid, b_hs, b_vs, b_ls, b_fs;
    logic [1:0] b_fc;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    vga_timing_gen #(.PIPE_DELAY(3)) u_a (
        .vga_clock(clk), .vga_reset_n(a_rst_n), .enable(a_en),
        .vga_col(a_col), .vga_row(a_row), .vga_valid(a_valid),
        .h_sync(a_hs), .v_sync(a_vs), .line_start(a_ls),
        .frame_start(a_fs), .frame_count(a_fc)
    );

    vga_timing_gen #(
        .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
        .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .H_SYNC_POL(1), .V_SYNC_POL(1), .PIPE_DELAY(1),
        .COORD_W(4), .FCOUNT_W(2)
    ) u_b (
        .vga_clock(clk), .vga_reset_n(b_rst_n), .enable(b_en),
        .vga_col(b_col), .vga_row(b_row), .vga_valid(b_valid),
        .h_sync(b_hs), .v_sync(b_vs), .line_start(b_ls),
        .frame_start(b_fs), .frame_count(b_fc)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int bound;
        int cnt;
        int vcnt;
        int lcnt;
        int n, p, pc, pr;
        int c_fs, c_ls, c_hs, c_vs, c_valid;
        logic [4:0] snap;

        a_rst_n = 1'b0; a_en = 1'b0; b_rst_n = 1'b0; b_en = 1'b0;
        repeat (3) tick();

        check("a_rst_col", a_col, 0);
        check("a_rst_row", a_row, 0);
        check("a_rst_fc", a_fc, 0);
        check("a_rst_flags", {a_fs, a_ls, a_vs, a_hs, a_valid}, 5'b00110);
        check("b_rst_flags", {b_fs, b_ls, b_vs, b_hs, b_valid}, 5'b00000);

        // ---------------- default timing, PIPE_DELAY=3 ----------------
        a_rst_n = 1'b1; a_en = 1'b1;
        tick();
        check("a_col_n1", a_col, 1);
        check("a_fs_n1", a_fs, 0);
        tick();
        check("a_fs_n2", a_fs, 0);
        tick();
        check("a_fs_n3", a_fs, 1);
        check("a_ls_n3", a_ls, 1);
        check("a_valid_n3", a_valid, 1);
        tick();
        check("a_fs_n4", a_fs, 0);

        bound = 0;
        while (a_col != 10'd656 && bound < 2000) begin tick(); bound++; end
        check("a_reach_c656", bound < 2000, 1);
        check("a_hs_c656", a_hs, 1);
        tick(); check("a_hs_c657", a_hs, 1);
        tick(); check("a_hs_c658", a_hs, 1);
        tick(); check("a_hs_c659", a_hs, 0);
        cnt = 1;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (a_hs == 1'b0) cnt++;
        end
        check("a_hs_width", cnt, 96);

        cnt = 0; vcnt = 0; lcnt = 0;
        for (int i = 0; i < 800; i++) begin
            tick();
            if (a_valid) cnt++;
            if (a_vs == 1'b0) vcnt++;
            if (a_ls) lcnt++;
        end
        check("a_valid_per_line", cnt, 640);
        check("a_vs_idle_row1", vcnt, 0);
        check("a_ls_per_line", lcnt, 1);

        bound = 0;
        while (!(a_row == 10'd10 && a_col == 10'd100) && bound < 20000) begin tick(); bound++; end
        check("a_reach_r10c100", bound < 20000, 1);
        check("a_valid_r10c100", a_valid, 1);
        a_en = 1'b0;
        snap = {a_fs, a_ls, a_vs, a_hs, a_valid};
        repeat (5) tick();
        check("a_freeze_col", a_col, 100);
        check("a_freeze_row", a_row, 10);
        check("a_freeze_flags", {a_fs, a_ls, a_vs, a_hs, a_valid}, snap);
        check("a_freeze_fc", a_fc, 0);
        a_en = 1'b1;
        tick();
        check("a_resume_col", a_col, 101);
        check("a_resume_row", a_row, 10);
        tick();
        check("a_resume_col2", a_col, 102);

        bound = 0;
        while (a_col != 10'd300 && bound < 2000) begin tick(); bound++; end
        check("a_reach_c300", bound < 2000, 1);
        check("a_valid_c300", a_valid, 1);
        #2;
        a_rst_n = 1'b0;
        #1;
        check("a_arst_col", a_col, 0);
        check("a_arst_row", a_row, 0);
        check("a_arst_fc", a_fc, 0);
        check("a_arst_flags", {a_fs, a_ls, a_vs, a_hs, a_valid}, 5'b00110);
        tick();
        check("a_arst_hold", a_col, 0);
        a_rst_n = 1'b1;
        tick();
        check("a_rel_col", a_col, 1);
        check("a_rel_fs1", a_fs, 0);
        tick();
        check("a_rel_fs2", a_fs, 0);
        tick();
        check("a_rel_fs3", a_fs, 1);
        check("a_rel_fc", a_fc, 0);

        // ---------------- tiny raster, positive syncs, FCOUNT_W=2 ----------------
        b_rst_n = 1'b1; b_en = 1'b1;
        tick();
        check("b_col_n1", b_col, 1);
        check("b_fs_n1", b_fs, 1);
        b_en = 1'b0;
        repeat (3) tick();
        check("b_stall_fs", b_fs, 1);
        check("b_stall_ls", b_ls, 1);
        check("b_stall_col", b_col, 1);
        check("b_stall_sync", {b_vs, b_hs}, 2'b00);
        b_en = 1'b1;

        c_fs = 1; c_ls = 1; c_hs = 0; c_vs = 0; c_valid = 1;
        for (n = 2; n <= 490; n++) begin
            tick();
            p  = n - 1;
            pc = p % 14;
            pr = (p / 14) % 7;
            check("b_col", b_col, n % 14);
            check("b_row", b_row, (n / 14) % 7);
            check("b_fc", b_fc, (n / 98) % 4);
            check("b_hs", b_hs, (pc >= 10 && pc < 12) ? 1 : 0);
            check("b_vs", b_vs, (pr == 5) ? 1 : 0);
            check("b_valid", b_valid, (pc < 8 && pr < 4) ? 1 : 0);
            check("b_ls", b_ls, (pc == 0) ? 1 : 0);
            check("b_fs", b_fs, (pc == 0 && pr == 0) ? 1 : 0);
            if (n % 98 == 0) check("b_fc_wrap", b_fc, (n / 98) % 4);
            c_fs    += int'(b_fs);
            c_ls    += int'(b_ls);
            c_hs    += int'(b_hs);
            c_vs    += int'(b_vs);
            c_valid += int'(b_valid);
        end
        check("b_fs_total", c_fs, 5);
        check("b_ls_total", c_ls, 35);
        check("b_hs_total", c_hs, 70);
        check("b_vs_total", c_vs, 70);
        check("b_valid_total", c_valid, 160);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
